// File: rtl/cm3_fft_pkg.sv
// cm3_fft_pkg: shared constants for the FFT power-spectrum stage.
// Holds default FFT geometry, bin packing offsets and log-output field widths.
// No logic; imported by the interface, the top and the log2 helper.
package cm3_fft_pkg;

  localparam int NFFT_DEF = 256;               // default FFT length (bins)
  localparam int CW_DEF   = 16;                // default signed component width
  localparam int BIN_W    = $clog2(NFFT_DEF);  // bin counter width for the default length

  localparam int DATA_W   = 32;                // stream data width, both sides
  localparam int RE_MSB   = 31;                // s_data[31:16] = re
  localparam int IM_MSB   = 15;                // s_data[15:0]  = im

  localparam int LOG_E_W  = 5;                 // log output: MSB index field
  localparam int LOG_F_W  = 11;                // log output: mantissa field below the MSB

endpackage

// File: rtl/cm3_fft_pwr_if.sv
// cm3_fft_pwr_if: bin-in / power-out valid-ready stream pair of the power stage.
// Ports: s_data/s_valid/s_ready (FFT bins in), m_data/m_valid/m_ready/m_last (power out).
// Modports: slave = the power stage itself, master = the environment driving it.
interface cm3_fft_pwr_if;
  import cm3_fft_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

endinterface

// File: rtl/cm3_fft_pwr_log2.sv
// cm3_fft_pwr_log2: combinational leading-one detector and mantissa extractor.
// Latency 0 (pure combinational, sits inside the S2 stage of the power block).
// Backpressure: none. Ports: val (32-bit) in, exp_o (MSB index), man_o (11 bits below MSB).
module cm3_fft_pwr_log2
  import cm3_fft_pkg::*;
(
  input  logic [DATA_W-1:0]  val,
  output logic [LOG_E_W-1:0] exp_o,
  output logic [LOG_F_W-1:0] man_o
);

  // val of 0 or 1 naturally yields exp_o=0 and man_o=0, so no special case is needed.
  always_comb begin
    exp_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (val[i]) exp_o = LOG_E_W'(i);
    end
    // Normalise so the leading one sits at bit 31, then take the 11 bits under it;
    // bits below bit 0 of val shift in as zeros.
    man_o = LOG_F_W'((val << (LOG_E_W'(DATA_W - 1) - exp_o)) >> (DATA_W - 1 - LOG_F_W));
  end

endmodule

// File: rtl/cm3_fft_pwr.sv
// cm3_fft_pwr: power spectrum (re^2+im^2)>>shift of bins 0..NFFT/2, marks last bin, counts frames.
// Latency 2 cycles (S1 squares, S2 sum+shift), 1 bin/cycle.
// Backpressure: full-pipeline stall, s_ready = en & (~m_valid | m_ready), no skid buffer.
// Ports: hclk, rst_n (async, active-low), clr (sync clear), en, shift[4:0],
//   str (cm3_fft_pwr_if.slave: s_data/s_valid/s_ready in, m_data/m_valid/m_ready/m_last out),
//   frame_done (pulse after bin NFFT-1 accepted), frame_cnt[15:0].
// Option: define CM3_FFT_PWR_LOG_EN to output {16'b0, msb_index[4:0], mantissa[10:0]} instead.
module cm3_fft_pwr
  import cm3_fft_pkg::*;
#(
  parameter int NFFT = NFFT_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic         hclk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [4:0]   shift,
  cm3_fft_pwr_if.slave str,
  output logic         frame_done,
  output logic [15:0]  frame_cnt
);

  localparam int            KW     = $clog2(NFFT);
  localparam int            PW     = 2 * CW + 1;
  localparam logic [KW-1:0] K_HALF = KW'(NFFT / 2);
  localparam logic [KW-1:0] K_LAST = KW'(NFFT - 1);

  // ---------------- state ----------------
  logic [KW-1:0]     k_q, k_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_last_q, s1_last_d;
  logic [2*CW-1:0]   s1_re2_q, s1_re2_d;
  logic [2*CW-1:0]   s1_im2_q, s1_im2_d;
  logic              m_vld_q, m_vld_d;
  logic              m_last_q, m_last_d;
  logic [DATA_W-1:0] m_dat_q, m_dat_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  // ---------------- handshake ----------------
  logic advance, s_rdy, accept;

  // Every stage moves together; the output register is the only place a stall can hold data.
  assign advance = ~m_vld_q | str.m_ready;
  assign s_rdy   = rst_n & en & advance;
  assign accept  = str.s_valid & s_rdy;

  // ---------------- S1 datapath ----------------
  logic signed [CW-1:0]   re, im;
  logic signed [2*CW-1:0] re_sq, im_sq;

  assign re    = str.s_data[RE_MSB -: CW];
  assign im    = str.s_data[IM_MSB -: CW];
  assign re_sq = re * re;
  assign im_sq = im * im;

  // ---------------- S2 datapath ----------------
  logic [PW-1:0]     pwr, pwr_sh;
  logic [DATA_W-1:0] lin_dat, s2_dat;

  assign pwr     = {1'b0, s1_re2_q} + {1'b0, s1_im2_q};
  assign pwr_sh  = pwr >> shift;
  assign lin_dat = DATA_W'(pwr_sh);

`ifdef CM3_FFT_PWR_LOG_EN
  logic [LOG_E_W-1:0] lg_e;
  logic [LOG_F_W-1:0] lg_f;

  cm3_fft_pwr_log2 u_log2 (
    .val   (lin_dat),
    .exp_o (lg_e),
    .man_o (lg_f)
  );

  assign s2_dat = {{(DATA_W - LOG_E_W - LOG_F_W){1'b0}}, lg_e, lg_f};
`else
  assign s2_dat = lin_dat;
`endif

  // ---------------- next state ----------------
  always_comb begin
    k_d          = k_q;
    s1_vld_d     = s1_vld_q;
    s1_last_d    = s1_last_q;
    s1_re2_d     = s1_re2_q;
    s1_im2_d     = s1_im2_q;
    m_vld_d      = m_vld_q;
    m_last_d     = m_last_q;
    m_dat_d      = m_dat_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (clr) begin
      // Clear wins over a same-cycle accept: that bin is dropped and the frame restarts.
      k_d         = '0;
      s1_vld_d    = 1'b0;
      s1_last_d   = 1'b0;
      m_vld_d     = 1'b0;
      m_last_d    = 1'b0;
      frame_cnt_d = '0;
    end else begin
      if (accept) begin
        k_d = k_q + 1'b1;  // power-of-two NFFT: wraps NFFT-1 -> 0 on its own
        if (k_q == K_LAST) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
      if (advance) begin
        // Upper-half bins are mirror images; they are consumed but leave a bubble.
        s1_vld_d  = accept && (k_q <= K_HALF);
        s1_last_d = accept && (k_q == K_HALF);
        if (accept) begin
          s1_re2_d = $unsigned(re_sq);
          s1_im2_d = $unsigned(im_sq);
        end
        m_vld_d  = s1_vld_q;
        m_last_d = s1_last_q;
        if (s1_vld_q) m_dat_d = s2_dat;
      end
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      k_q          <= '0;
      s1_vld_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_re2_q     <= '0;
      s1_im2_q     <= '0;
      m_vld_q      <= 1'b0;
      m_last_q     <= 1'b0;
      m_dat_q      <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      k_q          <= k_d;
      s1_vld_q     <= s1_vld_d;
      s1_last_q    <= s1_last_d;
      s1_re2_q     <= s1_re2_d;
      s1_im2_q     <= s1_im2_d;
      m_vld_q      <= m_vld_d;
      m_last_q     <= m_last_d;
      m_dat_q      <= m_dat_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // ---------------- outputs ----------------
  assign str.s_ready = s_rdy;
  assign str.m_data  = m_dat_q;
  assign str.m_valid = m_vld_q;
  assign str.m_last  = m_last_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cm3_fft_pwr.sv
// tb_cm3_fft_pwr: self-checking bench for cm3_fft_pwr (NFFT=256, CW=16).
// Directed table of isolated bins with exact latency, then randomized frames against a
// queue-based reference model; hand-written stall, clear and async-reset sequences.
module tb_cm3_fft_pwr;

  localparam int NFFT = 256;
  localparam int NOUT = NFFT / 2 + 1;

  logic        hclk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        en;
  logic [4:0]  shift;
  logic        frame_done;
  logic [15:0] frame_cnt;

  cm3_fft_pwr_if ifc ();

  cm3_fft_pwr #(.NFFT(NFFT), .CW(16)) dut (
    .hclk       (hclk),
    .rst_n      (rst_n),
    .clr        (clr),
    .en         (en),
    .shift      (shift),
    .str        (ifc),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 hclk = ~hclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_out(input logic [31:0] d, input logic [4:0] sh);
    longint re, im, p, v;
    int     e;
    re = longint'($signed(d[31:16]));
    im = longint'($signed(d[15:0]));
    p  = re * re + im * im;
    v  = (p >> sh) & 64'hFFFF_FFFF;
`ifdef CM3_FFT_PWR_LOG_EN
    if (v < 2) return 32'd0;
    e = 0;
    while ((longint'(1) << (e + 1)) <= v) e++;
    // integer part in [15:11], fractional part of v/2^e scaled by 2^11 in [10:0]
    return 32'(e * 2048 + (((v - (longint'(1) << e)) * 2048) >> e));
`else
    e = 0;
    return 32'(v + longint'(e));
`endif
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  exp_t        got_e;
  int          mk = 0;
  logic [15:0] mfcnt = '0;
  logic        fd_exp = 1'b0;
  logic        hold_vld = 1'b0;
  logic [31:0] hold_dat;
  logic        hold_last;
  int          n_out = 0;
  int          n_last = 0;
  int          n_fd = 0;

  // Monitor: samples mid-cycle what the coming rising edge will transfer.
  always @(negedge hclk) begin
    if (!rst_n) begin
      q.delete();
      mk       = 0;
      mfcnt    = '0;
      fd_exp   = 1'b0;
      hold_vld = 1'b0;
    end else begin
      chk("s_ready_rule", 32'(ifc.s_ready), 32'(en & (~ifc.m_valid | ifc.m_ready)));
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      chk("frame_cnt", 32'(frame_cnt), 32'(mfcnt));
      if (frame_done) n_fd++;
      if (hold_vld) begin
        chk("hold_valid", 32'(ifc.m_valid), 32'd1);
        chk("hold_data", ifc.m_data, hold_dat);
        chk("hold_last", 32'(ifc.m_last), 32'(hold_last));
      end
      hold_vld  = ifc.m_valid & ~ifc.m_ready & ~clr;
      hold_dat  = ifc.m_data;
      hold_last = ifc.m_last;
      if (ifc.m_valid && ifc.m_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got 0x%08h, expected no output (t=%0t)", ifc.m_data, $time);
        end else begin
          got_e = q.pop_front();
          chk("out_data", ifc.m_data, got_e.d);
          chk("out_last", 32'(ifc.m_last), 32'(got_e.l));
          n_out++;
          if (ifc.m_last) n_last++;
        end
      end
      fd_exp = 1'b0;
      if (clr) begin
        q.delete();
        mk    = 0;
        mfcnt = '0;
      end else if (ifc.s_valid && ifc.s_ready) begin
        if (mk <= NFFT / 2) begin
          mon_e.d = ref_out(ifc.s_data, shift);
          mon_e.l = (mk == NFFT / 2);
          q.push_back(mon_e);
        end
        if (mk == NFFT - 1) begin
          fd_exp = 1'b1;
          mfcnt  = mfcnt + 16'd1;
        end
        mk = (mk + 1) % NFFT;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rnd_bin();
    case ($urandom_range(7))
      0:       return 32'h8000_8000;
      1:       return 32'h7FFF_8001;
      2:       return 32'h0000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Offers bins until nbins have been accepted; valid/ready/en randomized by percentage.
  task automatic stream(input int nbins, input int vpct, input int rpct, input int epct);
    int got = 0;
    int cyc = 0;
    while (got < nbins && cyc < 20000) begin
      ifc.s_valid = ($urandom_range(99) < vpct);
      ifc.s_data  = rnd_bin();
      ifc.m_ready = ($urandom_range(99) < rpct);
      en          = ($urandom_range(99) < epct);
      @(negedge hclk);
      if (ifc.s_valid && ifc.s_ready) got++;
      tick();
      cyc++;
    end
    ifc.s_valid = 1'b0;
    en          = 1'b1;
    if (got < nbins) begin
      n_vec++;
      n_err++;
      $display("FAIL stream_timeout: accepted %0d bins, required %0d", got, nbins);
    end
  endtask

  task automatic drain();
    int c = 0;
    ifc.s_valid = 1'b0;
    ifc.m_ready = 1'b1;
    while ((q.size() != 0 || ifc.m_valid) && c < 50) begin
      tick();
      c++;
    end
    tick();
    if (c >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0", q.size());
    end
  endtask

  task automatic seg_chk(input string nm, input int e_out, input int e_fcnt);
    @(negedge hclk);
    chk({nm, "_outputs"}, 32'(n_out), 32'(e_out));
    chk({nm, "_lasts"}, 32'(n_last), 32'(e_out / NOUT));
    chk({nm, "_frame_done"}, 32'(n_fd), 32'(e_out / NOUT));
    chk({nm, "_frame_cnt"}, 32'(frame_cnt), 32'(e_fcnt));
    tick();
    n_out  = 0;
    n_last = 0;
    n_fd   = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [4:0]  sh;
    logic [31:0] exp_lin;
    logic [31:0] exp_log;
  } vec_t;

  vec_t tv[10];

  initial begin
    logic [31:0] exp_v;

    tv[0] = '{16'h0003, 16'h0004, 5'd0,  32'd25,         32'h0000_2480};
    tv[1] = '{16'h8000, 16'h8000, 5'd0,  32'h8000_0000,  32'h0000_F800};
    tv[2] = '{16'h0010, 16'h0000, 5'd4,  32'd16,         32'h0000_2000};
    tv[3] = '{16'h0000, 16'h0000, 5'd0,  32'd0,          32'h0000_0000};
    tv[4] = '{16'hFFFF, 16'h0001, 5'd0,  32'd2,          32'h0000_0800};
    tv[5] = '{16'h7FFF, 16'h8000, 5'd0,  32'h7FFF_0001,  32'h0000_F7FF};
    tv[6] = '{16'h8000, 16'h8000, 5'd31, 32'd1,          32'h0000_0000};
    tv[7] = '{16'h0064, 16'hFF38, 5'd3,  32'd6250,       32'h0000_6435};
    tv[8] = '{16'h0020, 16'h0000, 5'd0,  32'd1024,       32'h0000_5000};
    tv[9] = '{16'h0048, 16'h001F, 5'd2,  32'd1536,       32'h0000_5400};

    rst_n       = 1'b1;
    clr         = 1'b0;
    en          = 1'b1;
    shift       = 5'd0;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    ifc.m_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_s_ready", 32'(ifc.s_ready), 32'd0);
    chk("rst_m_valid", 32'(ifc.m_valid), 32'd0);
    chk("rst_m_data", ifc.m_data, 32'd0);
    chk("rst_m_last", 32'(ifc.m_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(posedge hclk);
    #2 rst_n = 1'b1;
    tick();

    // Isolated bins k=0..9: exact two-cycle latency and value.
    for (int i = 0; i < 10; i++) begin
      shift       = tv[i].sh;
      ifc.s_data  = {tv[i].re, tv[i].im};
      ifc.s_valid = 1'b1;
`ifdef CM3_FFT_PWR_LOG_EN
      exp_v = tv[i].exp_log;
`else
      exp_v = tv[i].exp_lin;
`endif
      @(negedge hclk);
      chk($sformatf("tbl%0d_s_ready", i), 32'(ifc.s_ready), 32'd1);
      tick();
      ifc.s_valid = 1'b0;
      @(negedge hclk);
      chk($sformatf("tbl%0d_t1_valid", i), 32'(ifc.m_valid), 32'd0);
      tick();
      @(negedge hclk);
      chk($sformatf("tbl%0d_t2_valid", i), 32'(ifc.m_valid), 32'd1);
      chk($sformatf("tbl%0d_data", i), ifc.m_data, exp_v);
      chk($sformatf("tbl%0d_last", i), 32'(ifc.m_last), 32'd0);
      tick();
    end
    drain();
    n_out = 0;
    n_last = 0;
    n_fd = 0;

    // Restart framing, then one full-rate frame.
    shift = 5'd0;
    clr   = 1'b1;
    tick();
    clr = 1'b0;
    stream(NFFT, 100, 100, 100);
    drain();
    seg_chk("frame1", NOUT, 1);

    // Two frames back to back with no gap.
    stream(2 * NFFT, 100, 100, 100);
    drain();
    seg_chk("frames23", 2 * NOUT, 3);

    // Random valid/ready/enable with a new shift.
    shift = 5'($urandom_range(8));
    stream(NFFT, 70, 60, 90);
    drain();
    seg_chk("random", NOUT, 4);

    // Five-cycle downstream stall in the middle of a frame.
    stream(60, 100, 100, 100);
    ifc.m_ready = 1'b0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = rnd_bin();
    for (int c = 0; c < 5; c++) begin
      @(negedge hclk);
      chk($sformatf("stall%0d_s_ready", c), 32'(ifc.s_ready), 32'd0);
      tick();
    end
    stream(NFFT - 60, 100, 100, 100);
    drain();
    seg_chk("stall", NOUT, 5);

    // Clear after 50 bins with a simultaneous (dropped) input.
    shift = 5'd0;
    stream(50, 100, 100, 100);
    ifc.s_valid = 1'b1;
    ifc.s_data  = rnd_bin();
    clr         = 1'b1;
    tick();
    clr         = 1'b0;
    ifc.s_valid = 1'b0;
    @(negedge hclk);
    chk("clr_m_valid", 32'(ifc.m_valid), 32'd0);
    chk("clr_frame_cnt", 32'(frame_cnt), 32'd0);
    tick();
    n_out = 0;
    n_last = 0;
    n_fd = 0;
    stream(NFFT, 100, 100, 100);
    drain();
    seg_chk("after_clr", NOUT, 1);

    // Asynchronous reset while the output is stalled.
    stream(30, 100, 100, 100);
    ifc.m_ready = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s_ready", 32'(ifc.s_ready), 32'd0);
    chk("arst_m_valid", 32'(ifc.m_valid), 32'd0);
    chk("arst_m_data", ifc.m_data, 32'd0);
    chk("arst_m_last", 32'(ifc.m_last), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge hclk);
    #2 rst_n = 1'b1;
    tick();
    n_out = 0;
    n_last = 0;
    n_fd = 0;
    stream(NFFT, 100, 100, 100);
    drain();
    seg_chk("after_arst", NOUT, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish within 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cm3_fft_pwr.md
# cm3_fft_pwr

Power-spectrum stage placed directly downstream of the windowed FFT core's output stream, in front of the mel filterbank. It consumes packed complex FFT bins, forwards only the non-redundant half-spectrum (bins 0..NFFT/2), and computes re²+im² with a programmable right shift. It marks the last bin of each frame and counts completed frames. It is a valid/ready stream block with a 2-stage pipeline and a global stall.

## Interface
- NFFT, 256: FFT length in bins; power of two, 16..1024.
- CW, 16: signed width of each real/imag component.
- hclk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of counters and pipeline.
- en  in  1  stage enable; when low, s_ready=0.
- shift  in  5  right shift applied to power, 0..31.
- s_data  in  32  FFT bin; [31:16]=re, [15:0]=im, two's complement.
- s_valid  in  1  input bin valid.
- s_ready  out  1  input bin accepted when s_valid&s_ready.
- m_data  out  32  power (or log-power) of a forwarded bin.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  high with the m_data of bin NFFT/2.
- frame_done  out  1  one-cycle pulse when input bin NFFT-1 is accepted.
- frame_cnt  out  16  completed input frames, wraps at 0xFFFF→0.

## Operation
- Input bin counter k, log2(NFFT) bits, increments on every accepted input and wraps NFFT-1→0.
- Bins with k≤NFFT/2 enter the pipeline. Bins with k>NFFT/2 are accepted and discarded, creating a bubble.
- S1 registers re² and im² as unsigned 2·CW-bit values and tags the last bin (k==NFFT/2).
- S2 computes p = re²+im² (2·CW+1 bits; for CW=16, max 0x8000_0000, fits 32 bits), then m_data = p>>shift, zero-extended or truncated to 32 bits.
- The shift value is sampled at S2. Software changes it only between frames.
- frame_done and the frame_cnt increment occur on acceptance of k==NFFT-1.
- clr: k=0, both pipeline stage valids=0, frame_cnt=0. clr has priority over a same-cycle accept, and that input is dropped.
- en low: no acceptance. Pipeline contents still drain to m_*.

## Timing
- Reset values: s_ready=0 while rst_n low, m_data=0, m_valid=0, m_last=0, frame_done=0, frame_cnt=0, k=0. After reset, s_ready=en&advance.
- advance = ~m_valid | m_ready. All stages load only when advance=1, and s_ready=en&advance (a full-pipeline stall; there is no skid buffer).
- Latency: a bin accepted at cycle t appears on m_* at t+2 when there is no stall.
- Throughput: 1 bin/cycle.
- m_data, m_last and m_valid are held stable while m_valid&~m_ready.
- Wrap-around: after k==NFFT-1 the next accepted bin is k=0 of the next frame, with no gap required.
- Async reset mid-frame discards the partial frame. The next accepted bin is treated as k=0.

## Configuration
- CM3_FFT_PWR_LOG_EN defined: S2 outputs log2(p>>shift) instead of the linear value.
  - Format: m_data = {16'b0, e[4:0], f[10:0]}, where e is the MSB index of the shifted power and f is the 11 bits below the MSB, zero-padded on the right.
  - Shifted power of 0 or 1 gives m_data=0.
  - Latency and handshake are unchanged; the leading-one detect stays within S2.
- Undefined: linear output only, and no log logic is synthesised.

## Structure
- Shared package cm3_fft_pkg holds:
  - localparams NFFT_DEF=256 and CW_DEF=16;
  - BIN_W=$clog2(NFFT);
  - the log output field widths (5/11);
  - the packing offsets RE_MSB=31, IM_MSB=15.
- One sub-module, cm3_fft_pwr_log2: combinational 32-bit leading-one detector and mantissa extractor, instantiated only under CM3_FFT_PWR_LOG_EN.

## Test plan
- Linear power: NFFT=256, shift=0; bin0 re=3, im=4 → m_data=25 at t+2. Bin1 re=-32768, im=-32768 → 0x8000_0000. Shift=4 with re=16, im=0 → 16.
- Full frame: 256 bins with s_valid=1 continuously → exactly 129 outputs, m_last only on the 129th, one frame_done pulse, frame_cnt=1. A second frame back-to-back → 129 more outputs, frame_cnt=2.
- Backpressure: hold m_ready=0 for 5 cycles mid-frame → s_ready=0 in those cycles, m_data held stable, no loss or duplication; ordered sequence 0..128 verified.
- clr mid-frame after 50 bins → m_valid=0 next cycle, frame_cnt=0. The following 256 bins yield 129 outputs starting at bin 0.
- Async reset asserted during a stall → all outputs at their reset values immediately. After release, the first bin is k=0.
- CM3_FFT_PWR_LOG_EN: p=1024 → 0x5000; p=1536 → 0x5400; p=1 → 0; p=0x8000_0000 → 0xF800.
